// File: rtl/asi_arbiter_if.sv
// asi_arbiter_if: bundles the read-path, write-path and user memory port
// signals that pass through the read/write arbiter.
//   slave  : arbiter view. It takes the requests, strobes, addresses, write
//            data and mem_rdata, and drives the grants, usr_rdata and mem_*.
//   master : environment view. This is the AXI slave read/write paths plus
//            the memory model.
interface asi_arbiter_if #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_WSTRBW = AXI_DW/8
);
  // read path
  logic                  usr_rrequest;
  logic                  usr_rgrant;
  logic                  usr_re;
  logic                  usr_rlast;
  logic [AXI_AW-1:0]     usr_raddr;
  logic [AXI_DW-1:0]     usr_rdata;
  // write path
  logic                  usr_wrequest;
  logic                  usr_wgrant;
  logic                  usr_we;
  logic                  usr_wlast;
  logic [AXI_AW-1:0]     usr_waddr;
  logic [AXI_DW-1:0]     usr_wdata;
  logic [AXI_WSTRBW-1:0] usr_wstrb;
  // single-ported user memory
  logic                  mem_en;
  logic                  mem_we;
  logic [AXI_AW-1:0]     mem_addr;
  logic [AXI_DW-1:0]     mem_wdata;
  logic [AXI_WSTRBW-1:0] mem_be;
  logic [AXI_DW-1:0]     mem_rdata;

  modport slave (
    input  usr_rrequest, usr_re, usr_rlast, usr_raddr,
    output usr_rgrant, usr_rdata,
    input  usr_wrequest, usr_we, usr_wlast, usr_waddr, usr_wdata, usr_wstrb,
    output usr_wgrant,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output usr_rrequest, usr_re, usr_rlast, usr_raddr,
    input  usr_rgrant, usr_rdata,
    output usr_wrequest, usr_we, usr_wlast, usr_waddr, usr_wdata, usr_wstrb,
    input  usr_wgrant,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/asi_arbiter.sv
// asi_arbiter: burst-granular read/write arbiter in front of a single-ported
// user memory/register port. The arbiter grants one side at a time and holds
// that grant until the side's last beat. A starvation counter bounds how many
// consecutive priority-side bursts can pass while the other side waits.
//
// Ports:
//   usr_clk   : clock
//   usr_reset : synchronous, active-high reset
//   bus       : asi_arbiter_if.slave. It carries the read path (rrequest,
//               rgrant, re, rlast, raddr, rdata), the write path (wrequest,
//               wgrant, we, wlast, waddr, wdata, wstrb) and the memory port
//               (mem_en/we/addr/wdata/be/rdata).
//   arb_err   : sticky protocol error
//
// Optional feature: define ASI_ARBITER_PROTOCOL_CHECK_EN to build the
// protocol checker behind arb_err. Without it, arb_err is tied low.
module asi_arbiter #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_WSTRBW = AXI_DW/8,
  parameter int ASI_ARB    = 0,
  parameter int STARVE_LIM = 4
) (
  input  logic           usr_clk,
  input  logic           usr_reset,
  asi_arbiter_if.slave   bus,
  output logic           arb_err
);

  localparam int CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);
  localparam bit RD_PRI = (ASI_ARB != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  localparam state_t NPRI_ST = RD_PRI ? WR : RD;

  state_t           state, sel;
  logic             rgrant, wgrant;
  logic [CNT_W-1:0] cnt, cnt_eff;
  logic             r_end, w_end, decide;
  logic             pri_end, npri_end, npri_req, starved;

  assign r_end  = (state == RD) && bus.usr_re && bus.usr_rlast;
  assign w_end  = (state == WR) && bus.usr_we && bus.usr_wlast;
  assign decide = (state == IDLE) || r_end || w_end;

  assign pri_end  = RD_PRI ? r_end : w_end;
  assign npri_end = RD_PRI ? w_end : r_end;
  assign npri_req = RD_PRI ? bus.usr_wrequest : bus.usr_rrequest;

  // The count that the selection sees already includes the burst that is
  // ending. The limit therefore hands over right after the STARVE_LIM-th
  // consecutive priority burst, not one burst later.
  always_comb begin
    cnt_eff = cnt;
    if (pri_end)
      cnt_eff = !npri_req ? '0 : (cnt == LIM) ? cnt : cnt + CNT_W'(1);
    else if (npri_end && !npri_req)
      cnt_eff = '0;
  end

  assign starved = (STARVE_LIM != 0) && (cnt_eff == LIM);

  always_comb begin
    sel = IDLE;
    if (bus.usr_rrequest && bus.usr_wrequest)
      sel = (RD_PRI ^ starved) ? RD : WR;
    else if (bus.usr_rrequest)
      sel = RD;
    else if (bus.usr_wrequest)
      sel = WR;
  end

  // State, grants and starvation count only move in IDLE or on a last beat.
  // As a result, a grant is never withdrawn mid-burst.
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      state  <= IDLE;
      rgrant <= 1'b0;
      wgrant <= 1'b0;
      cnt    <= '0;
    end else if (decide) begin
      state  <= sel;
      rgrant <= (sel == RD);
      wgrant <= (sel == WR);
      cnt    <= (sel == NPRI_ST) ? '0 : cnt_eff;
    end
  end

  assign bus.usr_rgrant = rgrant;
  assign bus.usr_wgrant = wgrant;
  assign bus.usr_rdata  = bus.mem_rdata;

  // The memory port follows the registered owner only. Strobes from the
  // other side can never reach it. A reset cycle blanks the port, so an
  // aborted burst completes no beat.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (!usr_reset) begin
      case (state)
        RD: begin
          bus.mem_en   = bus.usr_re;
          bus.mem_addr = bus.usr_raddr;
          bus.mem_be   = '1;
        end
        WR: begin
          bus.mem_en    = bus.usr_we;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.usr_waddr;
          bus.mem_wdata = bus.usr_wdata;
          bus.mem_be    = bus.usr_wstrb;
        end
        default: ;
      endcase
    end
  end

`ifdef ASI_ARBITER_PROTOCOL_CHECK_EN
  logic viol, err_q;

  assign viol = (bus.usr_re && !rgrant) || (bus.usr_we && !wgrant) ||
                (bus.usr_rlast && !bus.usr_re) || (bus.usr_wlast && !bus.usr_we);

  always_ff @(posedge usr_clk) begin
    if (usr_reset)  err_q <= 1'b0;
    else if (viol)  err_q <= 1'b1;
  end

  assign arb_err = err_q;
`else
  assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_asi_arbiter.sv
// tb_asi_arbiter: directed scenarios plus a randomized burst traffic run.
// The random run is checked against a burst-level ownership model.
module tb_asi_arbiter;
  localparam int DW = 128, AW = 32, SW = DW/8, ARB = 0, LIM = 2;

  logic usr_clk = 1'b0;
  logic usr_reset = 1'b1;
  logic arb_err;
  int   n_cmp = 0, n_bad = 0;
  logic [SW-1:0] ones = '1;
`ifdef ASI_ARBITER_PROTOCOL_CHECK_EN
  logic exp_err = 1'b1;
`else
  logic exp_err = 1'b0;
`endif

  asi_arbiter_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_WSTRBW(SW)) bus ();

  asi_arbiter #(.AXI_DW(DW), .AXI_AW(AW), .AXI_WSTRBW(SW), .ASI_ARB(ARB), .STARVE_LIM(LIM)) dut (
    .usr_clk(usr_clk), .usr_reset(usr_reset), .bus(bus), .arb_err(arb_err));

  always #5 usr_clk = ~usr_clk;

  task automatic tick();
    @(posedge usr_clk); #1;
  endtask

  task automatic idle_inputs();
    bus.usr_rrequest = 0; bus.usr_re = 0; bus.usr_rlast = 0; bus.usr_raddr = '0;
    bus.usr_wrequest = 0; bus.usr_we = 0; bus.usr_wlast = 0; bus.usr_waddr = '0;
    bus.usr_wdata = '0; bus.usr_wstrb = '0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    usr_reset = 1; idle_inputs(); tick(); tick(); usr_reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.usr_rgrant !== 1'b0) begin n_bad++; $display("FAIL reset_rgrant: got %b want 0", bus.usr_rgrant); end
    n_cmp++; if (bus.usr_wgrant !== 1'b0) begin n_bad++; $display("FAIL reset_wgrant: got %b want 0", bus.usr_wgrant); end
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
    n_cmp++; if (arb_err !== 1'b0) begin n_bad++; $display("FAIL reset_arb_err: got %b want 0", arb_err); end
  endtask

  task automatic test_read_burst();
    logic [DW-1:0] rd;
    do_reset();
    bus.usr_rrequest = 1; #1;
    n_cmp++; if (bus.usr_rgrant !== 1'b0) begin n_bad++; $display("FAIL rb_no_comb_grant: got %b want 0", bus.usr_rgrant); end
    tick();
    n_cmp++; if (bus.usr_rgrant !== 1'b1) begin n_bad++; $display("FAIL rb_grant: got %b want 1", bus.usr_rgrant); end
    for (int i = 0; i < 4; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      bus.usr_re = 1; bus.usr_rlast = (i == 3); bus.usr_raddr = 32'h1000 + 16*i;
      bus.mem_rdata = rd;
      if (i == 3) bus.usr_rrequest = 0;
      #1;
      n_cmp++; if (bus.mem_en !== 1'b1) begin n_bad++; $display("FAIL rb_mem_en[%0d]: got %b want 1", i, bus.mem_en); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rb_mem_we[%0d]: got %b want 0", i, bus.mem_we); end
      n_cmp++; if (bus.mem_addr !== 32'h1000 + 16*i) begin n_bad++; $display("FAIL rb_addr[%0d]: got %h want %h", i, bus.mem_addr, 32'h1000 + 16*i); end
      n_cmp++; if (bus.mem_be !== ones) begin n_bad++; $display("FAIL rb_be[%0d]: got %h want %h", i, bus.mem_be, ones); end
      n_cmp++; if (bus.usr_rdata !== rd) begin n_bad++; $display("FAIL rb_rdata[%0d]: got %h want %h", i, bus.usr_rdata, rd); end
      tick();
      n_cmp++; if (bus.usr_rgrant !== (i != 3)) begin n_bad++; $display("FAIL rb_hold[%0d]: got %b want %b", i, bus.usr_rgrant, i != 3); end
    end
    bus.usr_re = 0; bus.usr_rlast = 0; #1;
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rb_idle_en: got %b want 0", bus.mem_en); end
  endtask

  task automatic test_write_priority();
    logic [DW-1:0] wd;
    do_reset();
    bus.usr_rrequest = 1; bus.usr_wrequest = 1; tick();
    n_cmp++; if (bus.usr_wgrant !== 1'b1 || bus.usr_rgrant !== 1'b0) begin n_bad++; $display("FAIL wp_first: got w%b r%b want w1 r0", bus.usr_wgrant, bus.usr_rgrant); end
    wd = {$urandom, $urandom, $urandom, $urandom};
    bus.usr_we = 1; bus.usr_wlast = 1; bus.usr_wrequest = 0; bus.usr_wdata = wd;
    bus.usr_wstrb = 16'hA5C3; bus.usr_waddr = 32'h2040; #1;
    n_cmp++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL wp_en_we: got %b%b want 11", bus.mem_en, bus.mem_we); end
    n_cmp++; if (bus.mem_wdata !== wd) begin n_bad++; $display("FAIL wp_wdata: got %h want %h", bus.mem_wdata, wd); end
    n_cmp++; if (bus.mem_be !== 16'hA5C3 || bus.mem_addr !== 32'h2040) begin n_bad++; $display("FAIL wp_be_addr: got %h/%h want a5c3/2040", bus.mem_be, bus.mem_addr); end
    tick();
    bus.usr_we = 0; bus.usr_wlast = 0;
    n_cmp++; if (bus.usr_rgrant !== 1'b1 || bus.usr_wgrant !== 1'b0) begin n_bad++; $display("FAIL wp_switch: got r%b w%b want r1 w0", bus.usr_rgrant, bus.usr_wgrant); end
    bus.usr_re = 1; bus.usr_rlast = 1; bus.usr_rrequest = 0; tick();
    bus.usr_re = 0; bus.usr_rlast = 0;
    n_cmp++; if (bus.usr_rgrant !== 1'b0) begin n_bad++; $display("FAIL wp_release: got %b want 0", bus.usr_rgrant); end
  endtask

  task automatic test_starvation();
    logic [5:0] pat = 6'b011011;  // bit k = 1 -> burst k goes to write
    do_reset();
    bus.usr_rrequest = 1; bus.usr_wrequest = 1; tick();
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (bus.usr_wgrant !== pat[k] || bus.usr_rgrant !== !pat[k]) begin
        n_bad++; $display("FAIL starve_seq[%0d]: got w%b r%b want w%b", k, bus.usr_wgrant, bus.usr_rgrant, pat[k]);
      end
      bus.usr_we = bus.usr_wgrant; bus.usr_wlast = bus.usr_wgrant;
      bus.usr_re = bus.usr_rgrant; bus.usr_rlast = bus.usr_rgrant;
      tick();
    end
    idle_inputs(); tick();
  endtask

  task automatic test_preempt();
    do_reset();
    bus.usr_rrequest = 1; tick();
    bus.usr_re = 1; bus.usr_raddr = 32'h300; bus.usr_wrequest = 1; bus.usr_wstrb = 16'h00FF; tick();
    n_cmp++; if (bus.usr_rgrant !== 1'b1 || bus.usr_wgrant !== 1'b0) begin n_bad++; $display("FAIL pre_hold1: got r%b w%b want r1 w0", bus.usr_rgrant, bus.usr_wgrant); end
    bus.usr_re = 0; tick();
    n_cmp++; if (bus.usr_rgrant !== 1'b1) begin n_bad++; $display("FAIL pre_hold2: got %b want 1", bus.usr_rgrant); end
    bus.usr_re = 1; bus.usr_rlast = 1; bus.usr_rrequest = 0; #1;
    n_cmp++; if (bus.mem_be !== ones || bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL pre_rd_be: got %h/%b want all-ones/0", bus.mem_be, bus.mem_we); end
    tick();
    bus.usr_re = 0; bus.usr_rlast = 0;
    n_cmp++; if (bus.usr_wgrant !== 1'b1 || bus.usr_rgrant !== 1'b0) begin n_bad++; $display("FAIL pre_switch: got w%b r%b want w1 r0", bus.usr_wgrant, bus.usr_rgrant); end
    bus.usr_we = 1; bus.usr_wlast = 1; bus.usr_wrequest = 0; #1;
    n_cmp++; if (bus.mem_be !== 16'h00FF || bus.mem_we !== 1'b1 || bus.mem_en !== 1'b1) begin n_bad++; $display("FAIL pre_wr_be: got %h/%b/%b want 00ff/1/1", bus.mem_be, bus.mem_we, bus.mem_en); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.usr_wrequest = 1; tick();
    bus.usr_we = 1; bus.usr_wstrb = '1; tick();
    usr_reset = 1; #1;
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mid_abort: got %b want 0", bus.mem_en); end
    tick();
    usr_reset = 0; idle_inputs(); #1;
    n_cmp++; if (bus.usr_wgrant !== 1'b0 || bus.usr_rgrant !== 1'b0) begin n_bad++; $display("FAIL rst_mid_grants: got w%b r%b want 0 0", bus.usr_wgrant, bus.usr_rgrant); end
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mid_en: got %b want 0", bus.mem_en); end
    bus.usr_rrequest = 1; tick();
    n_cmp++; if (bus.usr_rgrant !== 1'b1) begin n_bad++; $display("FAIL rst_mid_idle: got %b want 1", bus.usr_rgrant); end
    bus.usr_re = 1; bus.usr_rlast = 1; bus.usr_rrequest = 0; tick();
    idle_inputs();
  endtask

  task automatic test_protocol();
    do_reset();
    bus.usr_re = 1; #1;
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL prot_mem_en: got %b want 0", bus.mem_en); end
    tick();
    bus.usr_re = 0;
    n_cmp++; if (arb_err !== exp_err) begin n_bad++; $display("FAIL prot_set: got %b want %b", arb_err, exp_err); end
    tick(); tick(); tick();
    n_cmp++; if (arb_err !== exp_err) begin n_bad++; $display("FAIL prot_sticky: got %b want %b", arb_err, exp_err); end
    do_reset();
    n_cmp++; if (arb_err !== 1'b0) begin n_bad++; $display("FAIL prot_clear: got %b want 0", arb_err); end
    bus.usr_wlast = 1; tick();
    bus.usr_wlast = 0;
    n_cmp++; if (arb_err !== exp_err) begin n_bad++; $display("FAIL prot_wlast: got %b want %b", arb_err, exp_err); end
    do_reset();
  endtask

  // Random traffic. Each side owns a queue of bursts (rem = beats left).
  // The model tracks who owns the port and how many priority bursts have
  // finished back to back while the other side was waiting.
  task automatic test_random();
    int rem_r = 0, rem_w = 0, owner = 0, pri_run = 0, win;
    int pri_side = (ARB != 0) ? 1 : 2;
    int np_side  = 3 - pri_side;
    logic br, bw, lr, lw, rq, wq, np_req, fin;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd, md;
    logic [SW-1:0] ws;
    logic e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [SW-1:0] e_be;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      n_cmp++; if (bus.usr_rgrant !== (owner == 1)) begin n_bad++; $display("FAIL rnd_rgrant@%0d: got %b want %b", c, bus.usr_rgrant, owner == 1); end
      n_cmp++; if (bus.usr_wgrant !== (owner == 2)) begin n_bad++; $display("FAIL rnd_wgrant@%0d: got %b want %b", c, bus.usr_wgrant, owner == 2); end
      if (rem_r == 0 && $urandom_range(0, 2) == 0) rem_r = $urandom_range(1, 4);
      if (rem_w == 0 && $urandom_range(0, 2) == 0) rem_w = $urandom_range(1, 4);
      br = (owner == 1) && (rem_r > 0) && ($urandom_range(0, 3) != 0);
      bw = (owner == 2) && (rem_w > 0) && ($urandom_range(0, 3) != 0);
      lr = br && (rem_r == 1);
      lw = bw && (rem_w == 1);
      if (br) rem_r--;
      if (bw) rem_w--;
      if (lr && $urandom_range(0, 1) == 1) rem_r = $urandom_range(1, 4);
      if (lw && $urandom_range(0, 1) == 1) rem_w = $urandom_range(1, 4);
      rq = rem_r > 0; wq = rem_w > 0;
      ra = $urandom; wa = $urandom; ws = SW'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      md = {$urandom, $urandom, $urandom, $urandom};
      bus.usr_rrequest = rq; bus.usr_re = br; bus.usr_rlast = lr; bus.usr_raddr = ra;
      bus.usr_wrequest = wq; bus.usr_we = bw; bus.usr_wlast = lw; bus.usr_waddr = wa;
      bus.usr_wdata = wd; bus.usr_wstrb = ws; bus.mem_rdata = md;
      #1;
      e_en   = (owner == 1) ? br : (owner == 2) ? bw : 1'b0;
      e_we   = (owner == 2);
      e_addr = (owner == 1) ? ra : (owner == 2) ? wa : '0;
      e_be   = (owner == 1) ? ones : (owner == 2) ? ws : '0;
      n_cmp++; if (bus.mem_en !== e_en || bus.mem_we !== e_we) begin n_bad++; $display("FAIL rnd_en_we@%0d: got %b%b want %b%b", c, bus.mem_en, bus.mem_we, e_en, e_we); end
      n_cmp++; if (bus.mem_addr !== e_addr || bus.mem_be !== e_be) begin n_bad++; $display("FAIL rnd_addr_be@%0d: got %h/%h want %h/%h", c, bus.mem_addr, bus.mem_be, e_addr, e_be); end
      if (owner != 1) begin
        n_cmp++; if (bus.mem_wdata !== ((owner == 2) ? wd : '0)) begin n_bad++; $display("FAIL rnd_wdata@%0d: got %h", c, bus.mem_wdata); end
      end
      n_cmp++; if (bus.usr_rdata !== md) begin n_bad++; $display("FAIL rnd_rdata@%0d: got %h want %h", c, bus.usr_rdata, md); end
      n_cmp++; if (arb_err !== 1'b0) begin n_bad++; $display("FAIL rnd_arb_err@%0d: got %b want 0", c, arb_err); end
      // reference: who owns the port after this clock edge
      fin = (owner == 1 && lr) || (owner == 2 && lw);
      if (owner == 0 || fin) begin
        np_req = (np_side == 1) ? rq : wq;
        if (fin && owner == pri_side) pri_run = np_req ? ((pri_run + 1 > LIM) ? LIM : pri_run + 1) : 0;
        if (fin && owner == np_side && !np_req) pri_run = 0;
        if (rq && wq) win = (LIM != 0 && pri_run >= LIM) ? np_side : pri_side;
        else if (rq)  win = 1;
        else if (wq)  win = 2;
        else          win = 0;
        if (win == np_side) pri_run = 0;
        owner = win;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_read_burst();
    test_write_priority();
    test_starvation();
    test_preempt();
    test_reset_mid_burst();
    test_protocol();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
